// File: rtl/uart_rx_path.sv
// uart_rx_path: UART receive path (rxd sync, 16x oversampled 8N1/8x1 deserialiser, RX FIFO)
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   baud_div[15:0]          clk cycles per 16x sample tick (0 treated as 1)
//   trig_lvl[1:0]           rx_trig_o level: 0->1, 1->4, 2->8, 3->FIFO_DEPTH-2 bytes
//   parity_odd              1=odd, 0=even parity (parity build only)
//   rxd                     async serial input, idle high
//   rx_rd                   pop FIFO head
//   rx_data[7:0]            FIFO head (show-ahead), rx_empty, rx_count
//   rx_trig_o, rts          registered level trigger and active-low flow control
//   frame_err, parity_err, overrun_err   1-cycle error pulses
// Build option: define UART_RX_PARITY_EN for 8-data+parity+stop frames; otherwise 8N1 only.
module uart_rx_path #(
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_MARGIN = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   baud_div,
  input  logic [1:0]                    trig_lvl,
  input  logic                          parity_odd,
  input  logic                          rxd,
  input  logic                          rx_rd,
  output logic [7:0]                    rx_data,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_trig_o,
  output logic                          rts,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state;
  logic rxd_q, rxd_s, tick, push, full, rd_ok, wr_ok, need_high;
  logic [15:0] bcnt;
  logic [3:0] sc;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp, rp_n;
  logic [CW-1:0] cnt_n;
  logic [31:0] trig_thr;
`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif
  assign tick     = bcnt == 16'd0;
  // the stop bit is sampled mid-bit and the byte leaves the deserialiser on that very tick
  assign push     = tick && state == STOP && sc == 4'd15;
  assign full     = rx_count == CW'(FIFO_DEPTH);
  assign rd_ok    = rx_rd && !rx_empty;
  // a same-cycle pop frees the slot, so a full FIFO still accepts the byte
  assign wr_ok    = push && (!full || rd_ok);
  assign rp_n     = rp + AW'(rd_ok);
  assign cnt_n    = rx_count + CW'(wr_ok) - CW'(rd_ok);
  assign rx_empty = rx_count == '0;
  assign trig_thr = trig_lvl == 2'd0 ? 32'd1 : trig_lvl == 2'd1 ? 32'd4 :
                    trig_lvl == 2'd2 ? 32'd8 : 32'(FIFO_DEPTH - 2);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_q <= 1'b1;
      rxd_s <= 1'b1;
      bcnt  <= '0;
    end else begin
      rxd_q <= rxd;
      rxd_s <= rxd_q;
      bcnt  <= tick ? (baud_div == 16'd0 ? 16'd0 : baud_div - 16'd1) : bcnt - 16'd1;
    end
  end
  // sc is zeroed at mid-start, so every later mid-bit sample lands on sc==15
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sc        <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      need_high <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else if (tick) begin
      sc <= sc + 4'd1;
      case (state)
        IDLE: begin
          sc <= '0;
          // after a bad stop bit the line must return high before a new start counts
          if (rxd_s) need_high <= 1'b0;
          else if (!need_high) state <= START;
        end
        START: if (sc == 4'd7) begin
          state   <= rxd_s ? IDLE : DATA;
          sc      <= '0;
          bit_idx <= '0;
        end
        DATA: if (sc == 4'd15) begin
          shreg   <= {rxd_s, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (sc == 4'd15) begin
          par_bad <= rxd_s != (^shreg ^ parity_odd);
          state   <= STOP;
        end
`endif
        STOP: if (sc == 4'd15) begin
          need_high <= !rxd_s;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= shreg;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp          <= '0;
      rp          <= '0;
      rx_count    <= '0;
      rx_data     <= '0;
      rx_trig_o   <= 1'b0;
      rts         <= 1'b1;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      rp       <= rp_n;
      rx_count <= cnt_n;
      // registered show-ahead head; bypass when the new byte becomes the head
      if (cnt_n != '0) rx_data <= (wr_ok && wp == rp_n) ? shreg : mem[rp_n];
      rx_trig_o   <= 32'(rx_count) >= trig_thr;
      rts         <= 32'(rx_count) >= 32'(FIFO_DEPTH - RTS_MARGIN);
      frame_err   <= push && !rxd_s;
      overrun_err <= push && !wr_ok;
`ifdef UART_RX_PARITY_EN
      parity_err  <= push && par_bad;
`else
      parity_err  <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_path.sv
// tb_uart_rx_path: self-checking bench for uart_rx_path
module tb_uart_rx_path;
`ifdef UART_RX_PARITY_EN
  localparam int PUSH_OFS = 674;
`else
  localparam int PUSH_OFS = 610;
`endif
  logic clk = 1'b0, rst_n = 1'b0, parity_odd = 1'b0, rxd = 1'b1, rx_rd = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic [1:0] trig_lvl = 2'd0;
  logic [7:0] rx_data;
  logic [4:0] rx_count;
  logic rx_empty, rx_trig_o, rts, frame_err, parity_err, overrun_err;
  uart_rx_path #(.FIFO_DEPTH(16), .RTS_MARGIN(2)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .trig_lvl(trig_lvl),
    .parity_odd(parity_odd), .rxd(rxd), .rx_rd(rx_rd), .rx_data(rx_data),
    .rx_empty(rx_empty), .rx_count(rx_count), .rx_trig_o(rx_trig_o), .rts(rts),
    .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err)
  );
  always #5 clk = ~clk;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= rst_n ? edge_cnt + 1 : 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, wide_cnt = 0;
  logic fe_d = 1'b0, pe_d = 1'b0, ov_d = 1'b0;
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overrun_err) ov_cnt++;
    if ((frame_err && fe_d) || (parity_err && pe_d) || (overrun_err && ov_d)) wide_cnt++;
    fe_d = frame_err;
    pe_d = parity_err;
    ov_d = overrun_err;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  int tests = 0, fails = 0;
  logic [7:0] exp_q[$];
  typedef struct {
    logic [7:0] d;
    logic stop;
    logic pflip;
    logic exp_fe;
  } vec_t;
  vec_t vecs[6];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // lands on the negedge before an edge j with j%4==2, so the DUT detects the start on the tick at j+2
  task automatic align();
    @(negedge clk);
    while (edge_cnt % 4 != 2) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (64) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = ^d ^ parity_odd ^ pflip;
    repeat (64) @(negedge clk);
`else
    if (pflip) rxd = 1'b1;
`endif
    rxd = stop;
    repeat (64) @(negedge clk);
    rxd = 1'b1;
  endtask
  task automatic pop_byte();
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, " rx_data"}, rx_data, 8'h00);
    check({tag, " rx_empty"}, rx_empty, 1);
    check({tag, " rx_count"}, rx_count, 0);
    check({tag, " rx_trig_o"}, rx_trig_o, 0);
    check({tag, " rts"}, rts, 1);
    check({tag, " errs"}, {frame_err, parity_err, overrun_err}, 0);
  endtask
  initial begin
    int f0, p0, o0, n;
    logic exp_pe;
    vecs[0] = '{8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hC3, 1'b1, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    f0 = fe_cnt;
    rxd = 1'b0;
    repeat (24) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch rx_count", rx_count, 0);
    check("glitch frame_err", fe_cnt - f0, 0);
    foreach (vecs[i]) begin
`ifdef UART_RX_PARITY_EN
      exp_pe = vecs[i].pflip;
`else
      exp_pe = 1'b0;
`endif
      f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt;
      exp_q.push_back(vecs[i].d);
      align();
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].pflip);
      n = 0;
      while (rx_empty && n < 2000) begin @(negedge clk); n++; end
      repeat (10) @(negedge clk);
      check($sformatf("vec%0d rx_count", i), rx_count, 1);
      check($sformatf("vec%0d rx_data", i), rx_data, exp_q.pop_front());
      check($sformatf("vec%0d frame_err", i), fe_cnt - f0, 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d parity_err", i), pe_cnt - p0, 32'(exp_pe));
      check($sformatf("vec%0d overrun_err", i), ov_cnt - o0, 0);
      pop_byte();
      check($sformatf("vec%0d empty after pop", i), rx_empty, 1);
    end
    o0 = ov_cnt;
    for (int b = 0; b < 17; b++) begin
      if (b < 16) exp_q.push_back(8'(b));
      align();
      send_frame(8'(b), 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      if (b == 12) check("rts at count 13", rts, 0);
      if (b == 13) check("rts at count 14", rts, 1);
    end
    check("full rx_count", rx_count, 16);
    check("full overrun pulses", ov_cnt - o0, 1);
    check("full head", rx_data, exp_q[0]);
    o0 = ov_cnt;
    align();
    fork
      send_frame(8'h11, 1'b1, 1'b0);
      begin
        repeat (PUSH_OFS) @(negedge clk);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(8'h11);
    repeat (20) @(negedge clk);
    check("push+rd no overrun", ov_cnt - o0, 0);
    check("push+rd rx_count", rx_count, 16);
    check("push+rd head", rx_data, 8'h01);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drain%0d", k), rx_data, exp_q.pop_front());
      pop_byte();
    end
    check("drained empty", rx_empty, 1);
    pop_byte();
    check("underflow rx_count", rx_count, 0);
    check("underflow rx_data holds", rx_data, 8'h11);
    trig_lvl = 2'd1;
    for (int b = 0; b < 3; b++) begin
      align();
      send_frame(8'h21 + 8'(b), 1'b1, 1'b0);
      repeat (20) @(negedge clk);
    end
    check("trig at 3", rx_trig_o, 0);
    align();
    fork
      send_frame(8'h24, 1'b1, 1'b0);
      begin
        repeat (PUSH_OFS + 1) @(negedge clk);
        check("trig lag count", rx_count, 4);
        check("trig lag 1", rx_trig_o, 0);
        @(negedge clk);
        check("trig lag 2", rx_trig_o, 1);
      end
    join
    check("head after trig", rx_data, 8'h21);
    align();
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("midreset");
        rst_n = 1'b1;
      end
    join
    repeat (100) @(negedge clk);
    check("after midreset rx_count", rx_count, 0);
    check("pulse widths", wide_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
